// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider: ALU op codes, FSM state
// encodings, iteration count and a two's-complement helper.
package div_ctrl_pkg;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DIVZERO = 2'b01,
    BUSY    = 2'b10,
    DONE    = 2'b11
  } div_state_e;

  function automatic logic [31:0] twos_neg(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the unsigned divider.
module div_step (
  input  logic [31:0] rem,
  input  logic        dividend_msb,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic        q_bit
);

  logic [32:0] partial;
  logic [32:0] diff;

  assign partial = {rem, dividend_msb};
  assign diff    = partial - {1'b0, divisor};

  // rem < divisor always holds, so a set bit 32 of diff means a borrow.
  assign q_bit    = ~diff[32];
  assign rem_next = q_bit ? diff[31:0] : partial[31:0];

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU controller: operand capture, 32-iteration restoring
// divide, sign fix-up and pipeline stall/ready handshake.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        annul,
  input  logic        ext_stall,
  output logic        stall,
  output logic        ready,
  output logic [63:0] result
);

  div_state_e       state;
  logic [CNT_W-1:0] count;
  logic [31:0]      divisor;
  logic [31:0]      rem;
  logic [31:0]      dq;
  logic             neg_q;
  logic             neg_r;

  logic [31:0] rem_next;
  logic        q_bit;
  logic [31:0] q_next;
  logic [31:0] abs1;
  logic [31:0] abs2;

  div_step u_step (
    .rem         (rem),
    .dividend_msb(dq[31]),
    .divisor     (divisor),
    .rem_next    (rem_next),
    .q_bit       (q_bit)
  );

  // Dividend bits shift out of dq's top while quotient bits shift in below.
  assign q_next = {dq[30:0], q_bit};
  assign abs1   = (signed_div && opdata1[31]) ? twos_neg(opdata1) : opdata1;
  assign abs2   = (signed_div && opdata2[31]) ? twos_neg(opdata2) : opdata2;

  assign ready = (state == DONE) && !annul;
  assign stall = resetn && !annul &&
                 (((state == IDLE) && start) || (state == BUSY) || (state == DIVZERO));

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      count   <= '0;
      divisor <= '0;
      rem     <= '0;
      dq      <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !annul) begin
            divisor <= abs2;
            dq      <= abs1;
            rem     <= '0;
            count   <= '0;
            neg_q   <= signed_div && (opdata1[31] ^ opdata2[31]);
            neg_r   <= signed_div && opdata1[31];
            state   <= (opdata2 == 32'd0) ? DIVZERO : BUSY;
          end
        end
        DIVZERO: begin
          if (annul) begin
            state <= IDLE;
          end else begin
            result <= '0;
            state  <= DONE;
          end
        end
        BUSY: begin
          if (annul) begin
            state <= IDLE;
          end else begin
            rem   <= rem_next;
            dq    <= q_next;
            count <= count + 1'b1;
            if (count == CNT_W'(DIV_CYCLES - 1)) begin
              result <= {neg_r ? twos_neg(rem_next) : rem_next,
                         neg_q ? twos_neg(q_next)   : q_next};
              state  <= DONE;
            end
          end
        end
        DONE: begin
          // Leaving DONE on !ext_stall is the pipeline advance; a start seen
          // in IDLE afterwards belongs to the next instruction.
          if (annul || !ext_stall) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus randomized
// operations compared every cycle against a latency-level behavioural model.
module tb_div_ctrl;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic        ext_stall;
  logic        stall;
  logic        ready;
  logic [63:0] result;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 0;

  div_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .annul     (annul),
    .ext_stall (ext_stall),
    .stall     (stall),
    .ready     (ready),
    .result    (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural divide result {remainder, quotient}; zero divisor gives 0.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return 64'd0;
    ua = (sgn && a[31]) ? 32'd0 - a : a;
    ub = (sgn && b[31]) ? 32'd0 - b : b;
    q  = ua / ub;
    r  = ua % ub;
    if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
    if (sgn && a[31])           r = 32'd0 - r;
    return {r, q};
  endfunction

  // Timing model: result appears a fixed number of cycles after start is
  // accepted (33 normally, 2 for a zero divisor) and is held while stalled.
  bit          m_act, m_done;
  int          m_cnt, m_lat;
  logic [63:0] m_final, m_res;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (!m_act) begin
      if (start && !annul) begin
        m_act   <= 1'b1;
        m_done  <= 1'b0;
        m_cnt   <= 1;
        m_lat   <= (opdata2 == 32'd0) ? 2 : 33;
        m_final <= ref_div(signed_div, opdata1, opdata2);
      end
    end else if (annul) begin
      m_act  <= 1'b0;
      m_done <= 1'b0;
    end else if (m_done) begin
      if (!ext_stall) begin
        m_act  <= 1'b0;
        m_done <= 1'b0;
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == m_lat) begin
        m_done <= 1'b1;
        m_res  <= m_final;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_ready", 64'(ready), 64'(m_act && m_done && !annul));
      check("cyc_stall", 64'(stall),
            64'(resetn && !annul && ((!m_act && start) || (m_act && !m_done))));
      check("cyc_result", result, m_res);
    end
  end

  // Drives one instruction; start is held until the pipeline advances or annul.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int annul_at,
                        output logic [63:0] res, output int lat,
                        output int nrdy, output int nstall);
    int t;
    bit fin;
    t = 0; fin = 0; lat = -1; nrdy = 0; nstall = 0; res = '0;
    start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
    ext_stall = (hold > 0);
    while (!fin && t < 80) begin
      annul = (t == annul_at);
      @(negedge clk);
      if (stall) nstall++;
      if (ready) begin
        if (lat < 0) lat = t;
        nrdy++;
        res = result;
      end
      fin = annul || (ready && !ext_stall);
      @(posedge clk);
      #1;
      if (nrdy >= hold) ext_stall = 1'b0;
      t++;
    end
    start = 1'b0; annul = 1'b0; ext_stall = 1'b0;
    check("op_terminated", 64'(fin), 64'd1);
  endtask

  logic [63:0] res;
  int lat, nrdy, nstall;

  initial begin
    resetn = 1'b1; start = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0; annul = 1'b0; ext_stall = 1'b0;
    #2 resetn = 1'b0;
    #1 cmp_en = 1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_result", result, 64'd0);

    run_op(1'b0, 32'd100, 32'd7, 0, -1, res, lat, nrdy, nstall);
    check("divu_100_7", res, {32'h0000_0002, 32'h0000_000E});
    check("divu_100_7_lat", 64'(lat), 64'd33);
    check("divu_100_7_stall", 64'(nstall), 64'd33);

    run_op(1'b1, 32'hFFFF_FFF9, 32'h2, 0, -1, res, lat, nrdy, nstall);
    check("div_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, res, lat, nrdy, nstall);
    check("div_min_m1", res, {32'h0, 32'h8000_0000});

    run_op(1'b0, 32'hFFFF_FFFF, 32'h1, 0, -1, res, lat, nrdy, nstall);
    check("divu_max_1", res, {32'h0, 32'hFFFF_FFFF});

    run_op(1'b1, 32'd5, 32'd0, 0, -1, res, lat, nrdy, nstall);
    check("div_5_0", res, 64'd0);
    check("div_5_0_lat", 64'(lat), 64'd2);
    check("div_5_0_stall", 64'(nstall), 64'd2);

    run_op(1'b0, 32'd1234, 32'd5, 0, 11, res, lat, nrdy, nstall);
    check("annul_busy_no_ready", 64'(nrdy), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, 0, -1, res, lat, nrdy, nstall);
    check("divu_9_3", res, {32'h0, 32'h3});

    run_op(1'b0, 32'd50, 32'd6, 3, -1, res, lat, nrdy, nstall);
    check("ext_stall_ready_cycles", 64'(nrdy), 64'd4);
    check("divu_50_6", res, {32'h2, 32'h8});

    run_op(1'b0, 32'd77, 32'd7, 3, 34, res, lat, nrdy, nstall);
    check("annul_done_ready_cycles", 64'(nrdy), 64'd1);
    check("divu_77_7", res, {32'h0, 32'd11});

    // start together with annul in IDLE must not launch an operation
    start = 1'b1; annul = 1'b1; opdata1 = 32'd8; opdata2 = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      int sel, hold, an;
      a   = $urandom();
      sel = $urandom_range(0, 15);
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'h8000_0000;
        3, 4, 5: b = 32'($urandom_range(1, 15));
        default: b = $urandom() >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      hold = $urandom_range(0, 2);
      an   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 35) : -1;
      run_op(1'($urandom_range(0, 1)), a, b, hold, an, res, lat, nrdy, nstall);
    end

    // asynchronous reset in the middle of a divide
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
    repeat (10) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("midbusy_reset_ready", 64'(ready), 64'd0);
    check("midbusy_reset_stall", 64'(stall), 64'd0);
    check("midbusy_reset_result", result, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
